// File: rtl/video_input_pkg.sv
// video_input_pkg: shared constants, state type and lane helper for the video input writer.
package video_input_pkg;

    localparam logic [15:0] HDR_TAG = 16'hF5A0;

    typedef enum logic {WAIT_SOF, IN_FRAME} vw_state_e;

    function automatic int ppw(input int pix_w);
        return 32 / pix_w;
    endfunction

endpackage

// File: rtl/vw_sync_fifo.sv
// vw_sync_fifo: single-clock FIFO; a push into a full FIFO is taken when a pop happens in the same cycle.
module vw_sync_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [AW:0]   r_cnt;
    logic          w_wr, w_rd;

    assign o_full  = r_cnt == (AW+1)'(DEPTH);
    assign o_empty = r_cnt == '0;
    assign w_rd    = i_pop & ~o_empty;
    assign w_wr    = i_push & (~o_full | w_rd);
    assign o_data  = r_mem[r_rd];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_wr) r_wr <= r_wr + 1'b1;
            if (w_rd) r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr] <= i_data;
    end

endmodule

// File: rtl/video_input_writer.sv
// video_input_writer: packs a framed pixel stream into 32-bit words, buffers them and
// writes them out over an Avalon-style writedata/write/waitrequest port.
module video_input_writer
    import video_input_pkg::*;
#(
    parameter int PIX_W      = 8,
    parameter int FIFO_DEPTH = 16,
    parameter bit HEADER_EN  = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_data,
    input  logic             pix_sof,
    input  logic             pix_eof,
    output logic [31:0]      out_writedata,
    output logic             out_write,
    input  logic             out_waitrequest,
    input  logic             clr_status,
    output logic             overflow,
    output logic             sync_err,
    output logic [15:0]      frame_cnt,
    output logic             busy
);
    localparam int PPW = ppw(PIX_W);
    localparam int LW  = (PPW > 1) ? $clog2(PPW) : 1;

    vw_state_e   r_state, w_state_nxt;
    logic [LW-1:0] r_lane;
    logic [31:0] r_word, r_hold, r_push, r_wdata;
    logic        r_hold_vld, r_push_vld, r_write, r_overflow, r_sync_err;
    logic [15:0] r_frame_cnt;

    logic          w_acc, w_sof, w_eof, w_restart, w_word_vld, w_hdr_vld;
    logic [LW-1:0] w_lane;
    logic [31:0]   w_word, w_hdr, w_sel, w_hold_nxt, w_head;
    logic          w_sel_vld, w_hold_vld_nxt, w_drop;
    logic          w_full, w_empty, w_load, w_pop, w_ovf_set;

    assign w_acc      = pix_valid & ((r_state == IN_FRAME) | (pix_sof & enable));
    assign w_sof      = w_acc & pix_sof;
    assign w_eof      = w_acc & pix_eof;
    assign w_restart  = pix_valid & pix_sof & (r_state == IN_FRAME);
    assign w_lane     = w_sof ? '0 : r_lane;
    assign w_word     = (w_sof ? 32'd0 : r_word) | (32'(pix_data) << (32'(w_lane) * PIX_W));
    assign w_word_vld = w_acc & (w_eof | (w_lane == LW'(PPW-1)));
    assign w_hdr_vld  = HEADER_EN & w_sof;
    assign w_hdr      = {HDR_TAG, r_frame_cnt};

    // Oldest word first: held word, then header, then the packed word; the one not taken waits in r_hold.
    assign w_sel_vld      = r_hold_vld | w_hdr_vld | w_word_vld;
    assign w_sel          = r_hold_vld ? r_hold : (w_hdr_vld ? w_hdr : w_word);
    assign w_hold_vld_nxt = r_hold_vld ? (w_hdr_vld | w_word_vld) : (w_hdr_vld & w_word_vld);
    assign w_hold_nxt     = (r_hold_vld & w_hdr_vld) ? w_hdr : w_word;
    assign w_drop         = r_hold_vld & w_hdr_vld & w_word_vld;

    assign w_load    = ~r_write | ~out_waitrequest;
    assign w_pop     = w_load & ~w_empty;
    assign w_ovf_set = w_drop | (r_push_vld & w_full & ~w_pop);

    vw_sync_fifo #(.W(32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (r_push_vld),
        .i_data  (r_push),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_state_nxt = r_state;
        if (w_acc) w_state_nxt = w_eof ? WAIT_SOF : IN_FRAME;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= WAIT_SOF;
            r_lane      <= '0;
            r_word      <= '0;
            r_hold_vld  <= 1'b0;
            r_hold      <= '0;
            r_push_vld  <= 1'b0;
            r_push      <= '0;
            r_frame_cnt <= '0;
            r_overflow  <= 1'b0;
            r_sync_err  <= 1'b0;
            r_write     <= 1'b0;
            r_wdata     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_acc) begin
                r_lane <= w_word_vld ? '0 : w_lane + 1'b1;
                r_word <= w_word_vld ? '0 : w_word;
            end
            r_hold_vld <= w_hold_vld_nxt;
            r_hold     <= w_hold_nxt;
            r_push_vld <= w_sel_vld;
            r_push     <= w_sel;
            if (w_eof) r_frame_cnt <= r_frame_cnt + 16'd1;
            r_overflow <= w_ovf_set | (r_overflow & ~clr_status);
            r_sync_err <= w_restart | (r_sync_err & ~clr_status);
            if (w_load) begin
                r_write <= ~w_empty;
                if (!w_empty) r_wdata <= w_head;
            end
        end
    end

    assign out_write     = r_write;
    assign out_writedata = r_wdata;
    assign overflow      = r_overflow;
    assign sync_err      = r_sync_err;
    assign frame_cnt     = r_frame_cnt;
    assign busy          = (r_state == IN_FRAME) | ~w_empty | r_write | r_push_vld | r_hold_vld;

endmodule

// File: tb/tb_video_input_writer.sv
// tb_video_input_writer: randomized frames checked against a word-list model of header + little-endian packing.
module tb_video_input_writer;
    localparam int PIX_W = 8;
    localparam int PPW   = 32 / PIX_W;
    localparam int DEPTH = 16;

    logic             clk = 1'b0, reset_n = 1'b0, enable = 1'b0;
    logic             pix_valid = 1'b0, pix_sof = 1'b0, pix_eof = 1'b0;
    logic [PIX_W-1:0] pix_data = '0;
    logic [31:0]      out_writedata;
    logic             out_write, out_waitrequest = 1'b0;
    logic             clr_status = 1'b0, overflow, sync_err, busy;
    logic [15:0]      frame_cnt;

    int          n_tests = 0, n_fail = 0, exp_cnt = 0;
    logic [31:0] exp_q[$];
    bit          wr_force = 1'b1, wr_val = 1'b0;
    int          wr_pct = 0;
    logic        stall_prev = 1'b0;
    logic [31:0] data_prev = '0;

    always #5 clk = ~clk;

    video_input_writer #(.PIX_W(PIX_W), .FIFO_DEPTH(DEPTH), .HEADER_EN(1'b1)) u_dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .enable          (enable),
        .pix_valid       (pix_valid),
        .pix_data        (pix_data),
        .pix_sof         (pix_sof),
        .pix_eof         (pix_eof),
        .out_writedata   (out_writedata),
        .out_write       (out_write),
        .out_waitrequest (out_waitrequest),
        .clr_status      (clr_status),
        .overflow        (overflow),
        .sync_err        (sync_err),
        .frame_cnt       (frame_cnt),
        .busy            (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(posedge clk) begin
        #2;
        out_waitrequest = wr_force ? wr_val : ($urandom_range(99) < wr_pct);
    end

    // A transfer seen here completes on the next rising edge; waitrequest only changes after that edge.
    always @(negedge clk) begin
        if (reset_n && stall_prev) begin
            check("hold_write", out_write, 1);
            check("hold_data", out_writedata, data_prev);
        end
        if (reset_n && out_write && !out_waitrequest) begin
            if (exp_q.size() == 0) check("spurious_write", out_write, 0);
            else check("wdata", out_writedata, exp_q.pop_front());
        end
        stall_prev = reset_n & out_write & out_waitrequest;
        data_prev  = out_writedata;
    end

    task automatic frame(input int n, input bit en, input int base);
        logic [PIX_W-1:0] px[$];
        logic [31:0]      w;
        for (int i = 0; i < n; i++) px.push_back(base < 0 ? PIX_W'($urandom) : PIX_W'(base + i));
        if (en) begin
            exp_q.push_back({16'hF5A0, 16'(exp_cnt)});
            for (int i = 0; i < n; i += PPW) begin
                w = '0;
                for (int j = 0; j < PPW && i + j < n; j++) w[PIX_W*j +: PIX_W] = px[i+j];
                exp_q.push_back(w);
            end
            exp_cnt++;
        end
        for (int i = 0; i < n; i++) begin
            while (base < 0 && $urandom_range(3) == 0) begin
                pix_valid = 1'b0;
                pix_sof   = 1'($urandom);
                pix_eof   = 1'($urandom);
                pix_data  = PIX_W'($urandom);
                cyc();
            end
            pix_valid = 1'b1;
            pix_sof   = (i == 0);
            pix_eof   = (i == n - 1);
            pix_data  = px[i];
            enable    = (i == 0) ? en : 1'($urandom);
            cyc();
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        pix_eof   = 1'b0;
        enable    = 1'b0;
        cyc(base < 0 ? 1 + $urandom_range(2) : 1);
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while (exp_q.size() != 0 && t < 1000) begin
            cyc();
            t++;
        end
        check(tag, 32'(exp_q.size()), 0);
        cyc(2);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        reset_n = 1'b0;
        cyc(2);
        check("rst_write", out_write, 0);
        check("rst_wdata", out_writedata, 0);
        check("rst_cnt", frame_cnt, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", overflow, 0);
        check("rst_serr", sync_err, 0);
        reset_n = 1'b1;
        cyc();

        // Directed 8-pixel frame with output latency checks.
        exp_q.push_back(32'hF5A00000);
        exp_q.push_back(32'h04030201);
        exp_q.push_back(32'h08070605);
        exp_cnt = 1;
        enable  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pix_valid = 1'b1;
            pix_sof   = (i == 0);
            pix_eof   = (i == 7);
            pix_data  = PIX_W'(i + 1);
            cyc();
            if (i == 1) check("lat_early", out_write, 0);
            if (i == 2) check("lat_rise", out_write, 1);
        end
        pix_valid = 1'b0;
        enable    = 1'b0;
        drain("f1_drain");
        check("f1_cnt", frame_cnt, 1);

        frame(6, 1'b1, 'h11);
        drain("f2_drain");
        check("f2_cnt", frame_cnt, 2);

        // 40-pixel frame with a 10-cycle waitrequest stall in the middle.
        wr_force = 1'b0;
        wr_pct   = 20;
        fork
            frame(40, 1'b1, -1);
            begin
                cyc(12);
                wr_force = 1'b1;
                wr_val   = 1'b1;
                cyc(10);
                wr_force = 1'b0;
            end
        join
        drain("stall_drain");
        check("stall_ovf", overflow, 0);

        frame(5, 1'b0, -1);
        drain("dis_drain");
        check("dis_cnt", frame_cnt, 16'(exp_cnt));

        // New sof after two pixels of an open frame.
        exp_q.push_back({16'hF5A0, 16'(exp_cnt)});
        enable = 1'b1;
        for (int i = 0; i < 2; i++) begin
            pix_valid = 1'b1;
            pix_sof   = (i == 0);
            pix_eof   = 1'b0;
            pix_data  = PIX_W'(8'hE0 + i);
            cyc();
        end
        pix_valid = 1'b0;
        cyc();
        check("serr_pre", sync_err, 0);
        check("cnt_open", frame_cnt, 16'(exp_cnt));
        frame(7, 1'b1, 'h30);
        check("serr_set", sync_err, 1);
        drain("restart_drain");
        check("restart_cnt", frame_cnt, 16'(exp_cnt));
        clr_status = 1'b1;
        cyc();
        clr_status = 1'b0;
        check("serr_clr", sync_err, 0);

        // Overflow: FIFO plus output stage hold DEPTH+1 words while stalled.
        wr_force = 1'b1;
        wr_val   = 1'b1;
        frame(80, 1'b1, -1);
        cyc(4);
        while (exp_q.size() > DEPTH + 1) void'(exp_q.pop_back());
        check("ovf_set", overflow, 1);
        clr_status = 1'b1;
        cyc();
        clr_status = 1'b0;
        check("ovf_clr", overflow, 0);
        check("ovf_busy", busy, 1);
        wr_force = 1'b0;
        wr_pct   = 0;
        drain("ovf_drain");
        check("ovf_cnt", frame_cnt, 16'(exp_cnt));

        // Random frames, random enables and random waitrequest.
        wr_pct = 30;
        for (int f = 0; f < 40; f++) frame($urandom_range(1, 24), $urandom_range(9) != 0, -1);
        drain("rnd_drain");
        check("rnd_cnt", frame_cnt, 16'(exp_cnt));
        check("rnd_ovf", overflow, 0);

        // Reset while a write is stalled.
        wr_force = 1'b1;
        wr_val   = 1'b1;
        frame(4, 1'b1, 'h40);
        t = 0;
        while (!out_write && t < 20) begin
            cyc();
            t++;
        end
        check("rstmid_pre", out_write, 1);
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        exp_q.delete();
        exp_cnt = 0;
        check("rstmid_write", out_write, 0);
        check("rstmid_cnt", frame_cnt, 0);
        check("rstmid_busy", busy, 0);
        wr_force = 1'b0;
        enable   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pix_valid = 1'b1;
            pix_sof   = 1'b0;
            pix_eof   = 1'($urandom);
            pix_data  = PIX_W'($urandom);
            cyc();
        end
        pix_valid = 1'b0;
        cyc(3);
        check("rstmid_ignore", busy, 0);
        frame(3, 1'b0, 'h60);
        frame(5, 1'b1, 'h50);
        drain("rstmid_drain");
        check("rstmid_cnt2", frame_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
